// File: rtl/ptosda_tx_pkg.sv
// Shared definitions for the two-wire parallel-to-serial transmitter:
// state encoding, frame slot counts and the frame-length helper.
package ptosda_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int START_SLOTS = 2;
    localparam int BIT_PHASES  = 4;
    localparam int STOP_PHASES = 4;
    localparam int GAP_SLOTS   = 2;

    // Wide enough for the longest phase sequence (4 phases).
    localparam int PH_W = 2;

    // clk cycles from acceptance edge to the edge that re-asserts ready
    function automatic int frame_clks(input int data_w, input int tick_div);
        return (START_SLOTS + BIT_PHASES * data_w + STOP_PHASES + GAP_SLOTS) * tick_div;
    endfunction

endpackage

// File: rtl/ptosda_tx_slot_tick_gen.sv
// Slot timer: emits a one-clk tick on the last clk of every TICK_DIV-clk slot
// while enabled; a synchronous clear restarts the slot.
module slot_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: clear wins, otherwise wrap at the slot end while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/ptosda_tx.sv
// Two-wire frame transmitter: accepts a word on valid/ready and sends
// start, DATA_W bits MSB first, stop and a bus-free gap on registered scl/sda.
module ptosda_tx
    import ptosda_tx_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              scl,
    output logic              sda
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]   BIT_LAST   = BW'(DATA_W - 1);
    localparam logic [PH_W-1:0] START_LAST = PH_W'(START_SLOTS - 1);
    localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_SLOTS - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              scl_q, scl_d;
    logic              sda_q, sda_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept_s;
    logic              tick_s;

    slot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (busy_q),
        .clr_i  (accept_s),
        .tick_o (tick_s)
    );

    // next-state logic; line values for a slot are loaded on the edge that starts it
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        scl_d    = scl_q;
        sda_d    = sda_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    accept_s = 1'b1;
                    state_d  = ST_START;
                    shift_d  = data;
                    bit_d    = '0;
                    phase_d  = '0;
                    scl_d    = 1'b1;
                    sda_d    = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    scl_d   = 1'b1;
                    sda_d   = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (phase_q == START_LAST) begin
                        state_d = ST_BIT;
                        phase_d = '0;
                        scl_d   = 1'b0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            ST_BIT: begin
                if (tick_s) begin
                    case (phase_q)
                        2'd0: begin
                            phase_d = 2'd1;
                            sda_d   = shift_q[DATA_W-1];
                        end
                        2'd1: begin
                            phase_d = 2'd2;
                            scl_d   = 1'b1;
                        end
                        2'd2: begin
                            phase_d = 2'd3;
                        end
                        2'd3: begin
                            phase_d = 2'd0;
                            scl_d   = 1'b0;
                            shift_d = shift_q << 1;
                            if (bit_q == BIT_LAST) begin
                                state_d = ST_STOP;
                                bit_d   = '0;
                            end else begin
                                bit_d = bit_q + BW'(1);
                            end
                        end
                        default: begin
                            phase_d = '0;
                        end
                    endcase
                end else begin
                    phase_d = phase_q;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    case (phase_q)
                        2'd0: begin
                            phase_d = 2'd1;
                            sda_d   = 1'b0;
                        end
                        2'd1: begin
                            phase_d = 2'd2;
                            scl_d   = 1'b1;
                        end
                        2'd2: begin
                            phase_d = 2'd3;
                            sda_d   = 1'b1;
                        end
                        2'd3: begin
                            state_d = ST_GAP;
                            phase_d = '0;
                        end
                        default: begin
                            phase_d = '0;
                        end
                    endcase
                end else begin
                    phase_d = phase_q;
                end
            end
            ST_GAP: begin
                if (tick_s) begin
                    if (phase_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                bit_d   = '0;
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state and output registers; reset aborts any frame with the bus released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign scl   = scl_q;
    assign sda   = sda_q;

endmodule

// File: tb/tb_ptosda_tx.sv
// Scoreboard bench: two transmitters (TICK_DIV 4 and 1) feed a behavioural
// two-wire receiver; received words and handshake timing are compared to a model.
module tb_ptosda_tx;

    localparam int DW  = 4;
    localparam int TD0 = 4;
    localparam int TD1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] data_s  [2];
    logic          valid_s [2];
    logic          ready_s [2];
    logic          busy_s  [2];
    logic          done_s  [2];
    logic          scl_s   [2];
    logic          sda_s   [2];

    ptosda_tx #(.DATA_W(DW), .TICK_DIV(TD0)) dut0 (
        .clk(clk), .rst_n(rst_n), .data(data_s[0]), .valid(valid_s[0]),
        .ready(ready_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .scl(scl_s[0]), .sda(sda_s[0])
    );

    ptosda_tx #(.DATA_W(DW), .TICK_DIV(TD1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data(data_s[1]), .valid(valid_s[1]),
        .ready(ready_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .scl(scl_s[1]), .sda(sda_s[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int td_of  [2] = '{TD0, TD1};

    // reference model state
    int            free_at [2];
    int            done_at [2];
    int            acc_cnt [2];
    logic [DW-1:0] exp_q   [2][$];
    int            start_q [2][$];

    // receiver state
    logic          pscl     [2];
    logic          psda     [2];
    int            in_frame [2];
    int            nbits    [2];
    logic [DW-1:0] word     [2];
    int            hi_run   [2];
    int            bit_hi   [2];
    int            viol     [2];
    int            rx_words [2];
    int            scl_tog  [2];

    function automatic int flen(input int td);
        return (2 + 4 * DW + 4 + 2) * td;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model of the handshake: a word is taken whenever valid is seen while idle
    initial begin
        for (int i = 0; i < 2; i++) begin
            free_at[i] = -1;
            done_at[i] = -10;
            acc_cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    free_at[i] = -1;
                    done_at[i] = -10;
                    exp_q[i].delete();
                    start_q[i].delete();
                end else if (valid_s[i] && cyc > free_at[i]) begin
                    exp_q[i].push_back(data_s[i]);
                    start_q[i].push_back(cyc + 1);
                    free_at[i] = cyc + flen(td_of[i]);
                    done_at[i] = free_at[i] + 1;
                    acc_cnt[i]++;
                end
            end
            cyc++;
        end
    end

    task automatic mon_step(input int i);
        logic c;
        logic d;
        c = scl_s[i];
        d = sda_s[i];
        chk($sformatf("ready%0d", i), ready_s[i], (cyc > free_at[i]) ? 1 : 0);
        chk($sformatf("busy%0d", i), busy_s[i], (cyc > free_at[i]) ? 0 : 1);
        chk($sformatf("done%0d", i), done_s[i], (cyc == done_at[i]) ? 1 : 0);
        if (c !== pscl[i]) scl_tog[i]++;
        if (!rst_n) begin
            in_frame[i] = 0;
            bit_hi[i]   = 0;
            hi_run[i]   = 0;
        end else begin
            if (pscl[i] && c && d !== psda[i]) begin
                if (!d) begin
                    if (in_frame[i] != 0) viol[i]++;
                    in_frame[i] = 1;
                    nbits[i]    = 0;
                    word[i]     = '0;
                    chk($sformatf("start_pending%0d", i), (start_q[i].size() > 0) ? 1 : 0, 1);
                    if (start_q[i].size() > 0)
                        chk($sformatf("start_time%0d", i), cyc, start_q[i].pop_front());
                end else begin
                    chk($sformatf("stop_bits%0d", i), (in_frame[i] != 0) ? nbits[i] : -1, DW);
                    chk($sformatf("word_pending%0d", i), (exp_q[i].size() > 0) ? 1 : 0, 1);
                    if (exp_q[i].size() > 0)
                        chk($sformatf("rx_word%0d", i), word[i], exp_q[i].pop_front());
                    rx_words[i]++;
                    in_frame[i] = 0;
                end
            end else if (c !== pscl[i] && d !== psda[i]) begin
                viol[i]++;
            end
            if (!pscl[i] && c) begin
                hi_run[i] = 1;
                if (in_frame[i] == 0) begin
                    viol[i]++;
                    bit_hi[i] = 0;
                end else if (nbits[i] < DW) begin
                    word[i]   = {word[i][DW-2:0], d};
                    nbits[i]++;
                    bit_hi[i] = 1;
                end else begin
                    bit_hi[i] = 0;
                end
            end else if (pscl[i] && c) begin
                hi_run[i]++;
            end else if (pscl[i] && !c) begin
                if (bit_hi[i] != 0)
                    chk($sformatf("scl_high_clks%0d", i), hi_run[i], 2 * td_of[i]);
                bit_hi[i] = 0;
            end
        end
        pscl[i] = c;
        psda[i] = d;
    endtask

    // receiver / monitor, sampled on the falling edge
    initial begin
        for (int i = 0; i < 2; i++) begin
            pscl[i] = 1'b1; psda[i] = 1'b1; in_frame[i] = 0; nbits[i] = 0;
            word[i] = '0; hi_run[i] = 0; bit_hi[i] = 0; viol[i] = 0;
            rx_words[i] = 0; scl_tog[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    end

    task automatic wait_acc(input int i, input int a0);
        int n;
        n = 0;
        while (acc_cnt[i] == a0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (acc_cnt[i] == a0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d: no acceptance within %0d clks", i, n);
        end
    endtask

    task automatic send(input int i, input logic [DW-1:0] w);
        int a0;
        a0 = acc_cnt[i];
        data_s[i]  = w;
        valid_s[i] = 1'b1;
        wait_acc(i, a0);
        valid_s[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (cyc <= free_at[i] + 2 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic chk_idle(input int i);
        chk($sformatf("rst_scl%0d", i), scl_s[i], 1);
        chk($sformatf("rst_sda%0d", i), sda_s[i], 1);
        chk($sformatf("rst_ready%0d", i), ready_s[i], 1);
        chk($sformatf("rst_busy%0d", i), busy_s[i], 0);
        chk($sformatf("rst_done%0d", i), done_s[i], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int tog0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_s[i] = 1'b0;
            data_s[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_idle(0);
        chk_idle(1);
        @(posedge clk); #1;

        send(0, 4'b1010);
        wait_idle(0);

        a0 = acc_cnt[0];
        data_s[0]  = 4'b0001;
        valid_s[0] = 1'b1;
        wait_acc(0, a0);
        data_s[0] = 4'b1111;
        wait_acc(0, a0 + 1);
        valid_s[0] = 1'b0;
        wait_idle(0);

        send(0, 4'($urandom_range(0, 15)));
        repeat (30) @(posedge clk);
        #1;
        data_s[0]  = 4'b0110;
        valid_s[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1 valid_s[0] = 1'b0;
        wait_idle(0);

        send(1, 4'b1000);
        wait_idle(1);

        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 2; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(i, 4'($urandom_range(0, 15)));
            end
        end
        wait_idle(0);
        wait_idle(1);

        send(0, 4'($urandom_range(0, 15)));
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_idle(0);
        tog0 = scl_tog[0];
        repeat (50) @(posedge clk);
        #1;
        chk("no_scl_toggle_after_reset", scl_tog[0] - tog0, 0);

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("protocol_violations%0d", i), viol[i], 0);
            chk($sformatf("left_in_queue%0d", i), exp_q[i].size(), 0);
        end
        chk("rx_words0", rx_words[0], 20);
        chk("rx_words1", rx_words[1], 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
